dpll_loop_filter: RTL and testbench
===================================

DPLL_LOOP_FILTER -- requirements
Module: dpll_loop_filter

Interface
REQ-001 Parameter CNT_W, default 8: width of threshold_i and of every event counter.
REQ-002 Parameter WINDOW, default 15: N-before-M window length M in counted events; legal range 1..2^CNT_W-1.
REQ-003 Parameter LOCK_CYCLES, default 1024: consecutive pulse-free cycles required for lock; legal range >= 2.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset, asynchronous, active-low.
REQ-006 forwarding_i  input  1  phase-lead indication from phase detector, sampled every cycle.
REQ-007 slowing_i  input  1  phase-lag indication from phase detector, sampled every cycle.
REQ-008 mode_i  input  1  0 = random-walk, 1 = N-before-M.
REQ-009 threshold_i  input  CNT_W  unsigned trip count N; value 0 treated as 1.
REQ-010 positiveShift_o  output  1  one-cycle request to advance oscillator phase.
REQ-011 negativeShift_o  output  1  one-cycle request to retard oscillator phase.
REQ-012 locked_o  output  1  loop considered locked.

Function
REQ-013 Event per cycle: UP = forwarding_i & !slowing_i; DN = slowing_i & !forwarding_i; both or neither = no event, all counters hold.
REQ-014 Random-walk: signed counter acc, width CNT_W+1, reset 0; UP -> acc+1, DN -> acc-1.
REQ-015 Random-walk trip: when acc+1 == +N on UP, positiveShift_o = 1 next cycle, acc = 0; when acc-1 == -N on DN, negativeShift_o = 1 next cycle, acc = 0.
REQ-016 N-before-M: unsigned counters upCnt, dnCnt, winCnt (CNT_W bits, reset 0); each event increments winCnt and upCnt or dnCnt.
REQ-017 N-before-M trip: upCnt reaching N -> positiveShift_o next cycle; dnCnt reaching N -> negativeShift_o next cycle; all three counters cleared same edge.
REQ-018 N-before-M expiry: winCnt reaching WINDOW without a trip -> all counters cleared, no pulse; trip takes priority over expiry on same event.
REQ-019 Latency: exactly one cycle from qualifying event cycle to shift pulse; outputs registered, no combinational input-to-output path.
REQ-020 positiveShift_o and negativeShift_o never high in the same cycle; each pulse lasts exactly one cycle.
REQ-021 Back-to-back: with N = 1, a qualifying event every cycle yields a pulse every cycle.
REQ-022 mode_i change (sampled value differs from previous cycle): acc, upCnt, dnCnt, winCnt cleared; that cycle's event discarded; no pulse next cycle.
REQ-023 threshold_i lowered below current count: next qualifying event in that direction trips immediately (compare >=, not ==).
REQ-024 Lock counter: saturating, counts cycles with no shift pulse output; cleared to 0 in any cycle a shift pulse is output.
REQ-025 locked_o = 1 while lock counter == LOCK_CYCLES; deasserts the cycle after a shift pulse.

Reset
REQ-026 reset_i low: all counters 0, positiveShift_o = 0, negativeShift_o = 0, locked_o = 0 immediately, independent of clk_i.
REQ-027 Reset mid-operation discards partial counts; first pulse after release requires a full N qualifying events.
REQ-028 First edge after reset_i rises processes inputs normally; mode_i-change detection register resets to 0.

Structure
REQ-029 Package loop_filter_pkg holds mode enum (RANDOM_WALK = 0, N_BEFORE_M = 1) and default values of CNT_W, WINDOW, LOCK_CYCLES.
REQ-030 Lock counter and locked_o implemented as sub-module lock_detector (inputs: clk_i, reset_i, pulse; output: locked_o).
REQ-031 Target size 120-400 lines of RTL including sub-module.

Verification
REQ-032 Mode 0, N = 4, forwarding_i held 1, slowing_i 0 -> positiveShift_o pulses every 4 cycles, first pulse in cycle 5 after reset release.
REQ-033 Mode 0, N = 3, pattern UP,DN,UP,UP,UP -> single positiveShift_o pulse in the cycle after the fifth event; acc returns to 0.
REQ-034 Mode 1, N = 4, WINDOW = 6, events UP,DN,UP,DN,UP,DN -> window expiry, no pulse; then 4 consecutive DN -> one negativeShift_o pulse.
REQ-035 Both inputs high 10 cycles in either mode -> no counter change, no pulse.
REQ-036 LOCK_CYCLES = 16, no events 16 cycles -> locked_o = 1 from cycle 17; one trip -> locked_o = 0 the cycle after the pulse.
REQ-037 reset_i driven low asynchronously mid-count with acc = N-1 -> outputs 0 before next edge; after release N further UP needed for a pulse.

Source files
------------

// File: rtl/dpll_loop_filter_pkg.sv
// Shared types and default parameters for the DPLL digital loop filter.
package loop_filter_pkg;

    typedef enum logic {
        RANDOM_WALK = 1'b0,
        N_BEFORE_M  = 1'b1
    } lf_mode_e;

    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned WINDOW_DEF      = 15;
    localparam int unsigned LOCK_CYCLES_DEF = 1024;

endpackage

// File: rtl/dpll_loop_filter_if.sv
// Phase-detector / oscillator-control bundle seen by the loop filter.
interface dpll_loop_filter_if #(
    parameter int unsigned CNT_W = loop_filter_pkg::CNT_W_DEF
);
    logic             forwarding_i;
    logic             slowing_i;
    logic             mode_i;
    logic [CNT_W-1:0] threshold_i;
    logic             positiveShift_o;
    logic             negativeShift_o;
    logic             locked_o;

    modport master (
        output forwarding_i, slowing_i, mode_i, threshold_i,
        input  positiveShift_o, negativeShift_o, locked_o
    );

    modport slave (
        input  forwarding_i, slowing_i, mode_i, threshold_i,
        output positiveShift_o, negativeShift_o, locked_o
    );
endinterface

// File: rtl/dpll_loop_filter_lock_detector.sv
// Saturating count of pulse-free cycles; locked once the count reaches LOCK_CYCLES.
module lock_detector
    import loop_filter_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pulse_i,
    output logic locked_o
);
    localparam int unsigned    LW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

    logic [LW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pulse_i) begin
            cnt_d = '0;
        end else if (cnt_q != LOCK_MAX) begin
            cnt_d = cnt_q + LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign locked_o = (cnt_q == LOCK_MAX);
endmodule

// File: rtl/dpll_loop_filter.sv
// DPLL loop filter: random-walk or N-before-M filtering of phase-detector events
// into one-cycle oscillator shift requests, plus lock indication.
module dpll_loop_filter
    import loop_filter_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned WINDOW      = WINDOW_DEF,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dpll_loop_filter_if.slave lf
);
    // Two guard bits so the +/-N compares cannot wrap for any legal N.
    localparam int unsigned   AW      = CNT_W + 2;
    localparam logic [CNT_W:0] WIN_EXT = (CNT_W + 1)'(WINDOW);

    logic signed [CNT_W:0]   acc_q, acc_d;
    logic        [CNT_W-1:0] up_cnt_q, up_cnt_d;
    logic        [CNT_W-1:0] dn_cnt_q, dn_cnt_d;
    logic        [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic                    mode_q;
    logic                    pos_q, pos_d;
    logic                    neg_q, neg_d;

    logic                    ev_up, ev_dn, mode_chg;
    lf_mode_e                mode_cur;
    logic        [CNT_W-1:0] thr_eff;
    logic        [CNT_W:0]   thr_ext, up_inc, dn_inc, win_inc;
    logic signed [AW-1:0]    acc_ext, acc_inc, acc_dec, n_pos;

    assign ev_up    = lf.forwarding_i & ~lf.slowing_i;
    assign ev_dn    = lf.slowing_i & ~lf.forwarding_i;
    assign mode_cur = lf_mode_e'(lf.mode_i);
    assign mode_chg = lf.mode_i != mode_q;
    assign thr_eff  = (lf.threshold_i == '0) ? CNT_W'(1) : lf.threshold_i;
    assign thr_ext  = {1'b0, thr_eff};

    assign acc_ext = {acc_q[CNT_W], acc_q};
    assign acc_inc = acc_ext + AW'(1);
    assign acc_dec = acc_ext - AW'(1);
    assign n_pos   = {2'b00, thr_eff};

    assign up_inc  = {1'b0, up_cnt_q} + (CNT_W + 1)'(1);
    assign dn_inc  = {1'b0, dn_cnt_q} + (CNT_W + 1)'(1);
    assign win_inc = {1'b0, win_cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        acc_d     = acc_q;
        up_cnt_d  = up_cnt_q;
        dn_cnt_d  = dn_cnt_q;
        win_cnt_d = win_cnt_q;
        pos_d     = 1'b0;
        neg_d     = 1'b0;

        if (mode_chg) begin
            acc_d     = '0;
            up_cnt_d  = '0;
            dn_cnt_d  = '0;
            win_cnt_d = '0;
        end else if (mode_cur == RANDOM_WALK) begin
            // >= / <= so a threshold lowered under the current count trips at once.
            if (ev_up) begin
                if (acc_inc >= n_pos) begin
                    pos_d = 1'b1;
                    acc_d = '0;
                end else begin
                    acc_d = acc_inc[CNT_W:0];
                end
            end else if (ev_dn) begin
                if (acc_dec <= -n_pos) begin
                    neg_d = 1'b1;
                    acc_d = '0;
                end else begin
                    acc_d = acc_dec[CNT_W:0];
                end
            end
        end else if (ev_up || ev_dn) begin
            if (ev_up && (up_inc >= thr_ext)) begin
                pos_d     = 1'b1;
                up_cnt_d  = '0;
                dn_cnt_d  = '0;
                win_cnt_d = '0;
            end else if (ev_dn && (dn_inc >= thr_ext)) begin
                neg_d     = 1'b1;
                up_cnt_d  = '0;
                dn_cnt_d  = '0;
                win_cnt_d = '0;
            end else if (win_inc >= WIN_EXT) begin
                up_cnt_d  = '0;
                dn_cnt_d  = '0;
                win_cnt_d = '0;
            end else begin
                win_cnt_d = win_inc[CNT_W-1:0];
                if (ev_up) begin
                    up_cnt_d = up_inc[CNT_W-1:0];
                end else begin
                    dn_cnt_d = dn_inc[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q     <= '0;
            up_cnt_q  <= '0;
            dn_cnt_q  <= '0;
            win_cnt_q <= '0;
            mode_q    <= 1'b0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            up_cnt_q  <= up_cnt_d;
            dn_cnt_q  <= dn_cnt_d;
            win_cnt_q <= win_cnt_d;
            mode_q    <= lf.mode_i;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
        end
    end

    assign lf.positiveShift_o = pos_q;
    assign lf.negativeShift_o = neg_q;

    lock_detector #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .pulse_i  (pos_q | neg_q),
        .locked_o (lf.locked_o)
    );
endmodule

// File: tb/tb_dpll_loop_filter.sv
// Directed bench for dpll_loop_filter (CNT_W=8, WINDOW=6, LOCK_CYCLES=16).
module tb_dpll_loop_filter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dpll_loop_filter_if #(.CNT_W(8)) bus ();

    dpll_loop_filter #(
        .CNT_W       (8),
        .WINDOW      (6),
        .LOCK_CYCLES (16)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .lf      (bus.slave)
    );

    // Apply one cycle of inputs; returns at the following negedge where the
    // registered response to that cycle is visible.
    task automatic drive(input logic f, input logic s);
        bus.forwarding_i = f;
        bus.slowing_i    = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.forwarding_i = 1'b0;
        bus.slowing_i    = 1'b0;
        bus.mode_i       = 1'b0;
        bus.threshold_i  = 8'd4;
        #12;
        checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL reset_pos got %b exp 0", bus.positiveShift_o); end
        checks++; if (bus.negativeShift_o !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", bus.negativeShift_o); end
        checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", bus.locked_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rw_hold_fwd();
        bus.threshold_i = 8'd4;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0);
            checks++; if (bus.positiveShift_o !== ((i % 4) == 3)) begin errors++; $display("FAIL rw_hold_pos cyc %0d got %b exp %b", i, bus.positiveShift_o, ((i % 4) == 3)); end
            checks++; if (bus.negativeShift_o !== 1'b0) begin errors++; $display("FAIL rw_hold_neg cyc %0d got %b exp 0", i, bus.negativeShift_o); end
        end
    endtask

    task automatic test_rw_pattern();
        logic [7:0] f_seq = 8'b0001_1101; // bit i = forwarding for event i: UP,DN,UP,UP,UP,UP,UP,UP
        logic [7:0] p_exp = 8'b1001_0000; // pulse after event 4 and after event 7
        bus.threshold_i = 8'd3;
        f_seq[7:5] = 3'b111;
        for (int i = 0; i < 8; i++) begin
            drive(f_seq[i], ~f_seq[i]);
            checks++; if (bus.positiveShift_o !== p_exp[i]) begin errors++; $display("FAIL rw_pattern_pos ev %0d got %b exp %b", i, bus.positiveShift_o, p_exp[i]); end
            checks++; if (bus.negativeShift_o !== 1'b0) begin errors++; $display("FAIL rw_pattern_neg ev %0d got %b exp 0", i, bus.negativeShift_o); end
        end
    endtask

    task automatic test_both_high();
        bus.threshold_i = 8'd3;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1);
            checks++; if ((bus.positiveShift_o | bus.negativeShift_o) !== 1'b0) begin errors++; $display("FAIL both_high cyc %0d got pos %b neg %b exp 0", i, bus.positiveShift_o, bus.negativeShift_o); end
        end
        drive(1'b1, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b1) begin errors++; $display("FAIL both_high_resume got %b exp 1", bus.positiveShift_o); end
    endtask

    task automatic test_mode_change_window();
        logic [5:0] f_seq = 6'b010101; // UP,DN,UP,DN,UP,DN
        bus.threshold_i = 8'd3;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        bus.mode_i = 1'b1;
        drive(1'b1, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL mode_change_pulse got %b exp 0", bus.positiveShift_o); end
        bus.threshold_i = 8'd4;
        for (int i = 0; i < 6; i++) begin
            drive(f_seq[i], ~f_seq[i]);
            checks++; if ((bus.positiveShift_o | bus.negativeShift_o) !== 1'b0) begin errors++; $display("FAIL window_expiry ev %0d got pos %b neg %b exp 0", i, bus.positiveShift_o, bus.negativeShift_o); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1);
            checks++; if (bus.negativeShift_o !== (i == 3)) begin errors++; $display("FAIL nbm_dn_neg ev %0d got %b exp %b", i, bus.negativeShift_o, (i == 3)); end
            checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL nbm_dn_pos ev %0d got %b exp 0", i, bus.positiveShift_o); end
        end
    endtask

    task automatic test_threshold_lower();
        bus.threshold_i = 8'd4;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL thr_pre ev %0d got %b exp 0", i, bus.positiveShift_o); end
        end
        bus.threshold_i = 8'd2;
        drive(1'b1, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b1) begin errors++; $display("FAIL thr_lowered got %b exp 1", bus.positiveShift_o); end
        bus.threshold_i = 8'd0;
        drive(1'b1, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b1) begin errors++; $display("FAIL thr_zero_up got %b exp 1", bus.positiveShift_o); end
        drive(1'b0, 1'b1);
        checks++; if (bus.negativeShift_o !== 1'b1) begin errors++; $display("FAIL thr_zero_dn got %b exp 1", bus.negativeShift_o); end
        checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL thr_zero_excl got %b exp 0", bus.positiveShift_o); end
    endtask

    task automatic test_trip_priority();
        bus.threshold_i = 8'd6;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            checks++; if (bus.positiveShift_o !== (i == 5)) begin errors++; $display("FAIL trip_priority ev %0d got %b exp %b", i, bus.positiveShift_o, (i == 5)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f_seq = 8'b0101_0111; // UP,UP,UP,DN,UP,DN,UP,DN
        bus.threshold_i = 8'd1;
        for (int i = 0; i < 8; i++) begin
            drive(f_seq[i], ~f_seq[i]);
            checks++; if (bus.positiveShift_o !== f_seq[i]) begin errors++; $display("FAIL b2b_pos ev %0d got %b exp %b", i, bus.positiveShift_o, f_seq[i]); end
            checks++; if (bus.negativeShift_o !== ~f_seq[i]) begin errors++; $display("FAIL b2b_neg ev %0d got %b exp %b", i, bus.negativeShift_o, ~f_seq[i]); end
        end
    endtask

    task automatic test_lock();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0);
            checks++; if (bus.locked_o !== (k >= 17)) begin errors++; $display("FAIL lock_count idle %0d got %b exp %b", k, bus.locked_o, (k >= 17)); end
        end
        bus.threshold_i = 8'd1;
        drive(1'b1, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b1) begin errors++; $display("FAIL lock_trip_pos got %b exp 1", bus.positiveShift_o); end
        checks++; if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL lock_during_pulse got %b exp 1", bus.locked_o); end
        drive(1'b0, 1'b0);
        checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL lock_after_pulse got %b exp 0", bus.locked_o); end
    endtask

    task automatic test_async_reset();
        bus.mode_i      = 1'b0;
        bus.threshold_i = 8'd4;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 17; i++) drive(1'b0, 1'b0);
        checks++; if (bus.locked_o !== 1'b1) begin errors++; $display("FAIL pre_reset_locked got %b exp 1", bus.locked_o); end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.locked_o !== 1'b0) begin errors++; $display("FAIL async_locked got %b exp 0", bus.locked_o); end
        checks++; if ((bus.positiveShift_o | bus.negativeShift_o) !== 1'b0) begin errors++; $display("FAIL async_shift got pos %b neg %b exp 0", bus.positiveShift_o, bus.negativeShift_o); end
        bus.forwarding_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            checks++; if (bus.positiveShift_o !== (i == 3)) begin errors++; $display("FAIL post_reset_pos ev %0d got %b exp %b", i, bus.positiveShift_o, (i == 3)); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL async_pulse_kill got %b exp 0", bus.positiveShift_o); end
        bus.forwarding_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
        checks++; if (bus.positiveShift_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b exp 0", bus.positiveShift_o); end
    endtask

    initial begin
        test_reset();
        test_rw_hold_fwd();
        test_rw_pattern();
        test_both_high();
        test_mode_change_window();
        test_threshold_lower();
        test_trip_priority();
        test_back_to_back();
        test_lock();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
